tap_digit_ctrl: RTL and testbench
=================================

Name: tap_digit_ctrl

Overview:
- Sits directly downstream of the button conditioning chain (debounce, synchronize, one-shot); consumes its one-cycle press pulses.
- Single tap increments a 0..MAX_DIGIT digit after a double-tap window expires.
- Double tap inside the window clears the digit to 0.
- A separate decrement pulse acts immediately. Drives a 7-segment digit (segments a..g) for the display.

Parameters:
- MAX_DIGIT, 9, highest digit value before wrap to 0; legal range 1..9.
- DTAP_CYCLES, 5000000, double-tap window length in clk cycles; must be >= 2.
- TIMER_W, $clog2(DTAP_CYCLES), window timer width; derived, not overridden.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- inc_pulse  input  1  one-cycle tap pulse from the button one-shot.
- dec_pulse  input  1  one-cycle decrement pulse from a second button one-shot.
- digit  output  4  current digit value, registered.
- seg  output  7  {g,f,e,d,c,b,a}, active-high, decoded from digit.
- armed  output  1  high while a double-tap window is open.
- double_tap  output  1  one-cycle pulse on a detected double tap.
- dp  output  1  decimal point (see Optional Feature).

Behaviour:
- Reset: state IDLE, timer 0, digit 0, seg 7'h3F, armed 0, double_tap 0, dp 0. Reset overrides all inputs in the same cycle.
- FSM states are IDLE and ARMED; armed = (state == ARMED), registered.
- IDLE with inc_pulse: go to ARMED, load timer = DTAP_CYCLES-1.
- ARMED with inc_pulse: digit <= 0, double_tap = 1 for exactly one cycle, go to IDLE. This takes priority over timer expiry in the same cycle.
- ARMED with no inc_pulse and timer == 0: commit digit <= (digit == MAX_DIGIT) ? 0 : digit+1, go to IDLE.
- ARMED otherwise: timer decrements by 1.
- Timing: with the first pulse sampled at edge 0, a second pulse is accepted as a double tap at edges 1..DTAP_CYCLES. The single-tap commit is visible after edge DTAP_CYCLES.
- dec_pulse, any state: digit <= (digit == 0) ? MAX_DIGIT : digit-1, applied immediately. It does not touch state or timer.
- dec_pulse and single-tap commit in the same cycle: they cancel and digit is unchanged. The FSM still returns to IDLE.
- dec_pulse and double-tap clear in the same cycle: clear wins, digit = 0.
- inc_pulse held high for several cycles is treated as separate pulses; no other filtering is done.
- seg is combinational from the registered digit: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Any other code gives 00 (unreachable).
- Reset while ARMED discards the pending tap; no commit occurs.

Optional Feature:
- Macro: TAP_DP_BLINK_EN.
- Defined: dp = armed & timer[TIMER_W-1], so dp blinks while the window is open. dp is 0 in IDLE and in reset.
- Undefined: dp is tied to constant 0, with no added logic.

Decomposition:
- Package tap_digit_pkg holds the state enum (IDLE, ARMED), the 10-entry segment encoding constants, and SEG_BLANK = 7'h00.
- Sub-module seg7_decoder is combinational, maps digit[3:0] to seg[6:0], and is reusable for other display digits.
- FSM, timer and digit register stay in tap_digit_ctrl.

Test Plan (DTAP_CYCLES=8, MAX_DIGIT=9):
- Reset, then idle 20 cycles -> digit 0, seg 3F, armed 0, double_tap 0 throughout.
- Single inc_pulse at edge 0 -> armed 1 at edges 1..8. digit 0->1 and seg 06 after edge 8; no change after edge 7.
- Load digit 5 via taps; inc_pulse at edge 0 and edge 8 -> double_tap high for one cycle after edge 8, digit 0, armed 0. Repeating with the second pulse at edge 9 instead -> digit 6 after edge 8, and a new window opens at edge 9.
- Wraps: digit 9 + single tap -> 0. Digit 0 + dec_pulse -> 9, seg 6F, in the next cycle.
- dec_pulse coincident with the commit edge at digit 3 -> digit stays 3. dec_pulse coincident with a double-tap pulse -> digit 0.
- Reset asserted at edge 4 of an open window -> armed 0, digit unchanged by the pending tap, no double_tap. With TAP_DP_BLINK_EN defined, dp toggles only while armed.

Source files
------------

// File: rtl/tap_digit_pkg.sv
// Shared types and constants for the tap-driven digit controller.
//   state_t    : controller FSM states (IDLE, ARMED)
//   SEG_CODES  : 7-segment {g,f,e,d,c,b,a} patterns for digits 0..9
//   SEG_BLANK  : pattern for codes outside 0..9
// Optional feature macro used by the controller: TAP_DP_BLINK_EN.
package tap_digit_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned NUM_SEG_CODES = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  // Index n holds the pattern for digit n.
  localparam logic [NUM_SEG_CODES-1:0][SEG_W-1:0] SEG_CODES = {
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-digit to 7-segment decoder, active-high segments.
// Ports:
//   digit : 4-bit digit code, 0..9 meaningful
//   seg   : {g,f,e,d,c,b,a}; blank for codes above 9
module seg7_decoder
  import tap_digit_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit < DIGIT_W'(NUM_SEG_CODES)) begin
      seg = SEG_CODES[digit];
    end
  end

endmodule

// File: rtl/tap_digit_ctrl.sv
// Tap-driven single digit counter with double-tap clear and immediate
// decrement, driving one 7-segment display digit.
// A tap opens a double-tap window; a second tap inside it clears the
// digit, otherwise the digit increments (with wrap) when the window closes.
// Optional macro TAP_DP_BLINK_EN: blinks the decimal point while the
// window is open; when undefined dp is constant 0.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   inc_pulse  : one-cycle tap pulse
//   dec_pulse  : one-cycle decrement pulse
//   digit      : current digit, registered
//   seg        : 7-segment pattern decoded from digit
//   armed      : window open, registered
//   double_tap : one-cycle pulse on a detected double tap, registered
//   dp         : decimal point
module tap_digit_ctrl
  import tap_digit_pkg::*;
#(
  parameter int unsigned MAX_DIGIT   = 9,
  parameter int unsigned DTAP_CYCLES = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_pulse,
  input  logic               dec_pulse,
  output logic [DIGIT_W-1:0] digit,
  output logic [SEG_W-1:0]   seg,
  output logic               armed,
  output logic               double_tap,
  output logic               dp
);

  localparam int unsigned TIMER_W = $clog2(DTAP_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DTAP_CYCLES - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_MAX  = DIGIT_W'(MAX_DIGIT);

  state_t             state, state_n;
  logic [TIMER_W-1:0] timer, timer_n;
  logic [DIGIT_W-1:0] digit_n;
  logic               double_tap_n;
  logic               commit;
  logic               clear;

  // State, timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      digit      <= '0;
      armed      <= 1'b0;
      double_tap <= 1'b0;
    end else begin
      state      <= state_n;
      timer      <= timer_n;
      digit      <= digit_n;
      armed      <= (state_n == ARMED);
      double_tap <= double_tap_n;
    end
  end

  // Next-state, window timer and digit update.
  always_comb begin
    state_n      = state;
    timer_n      = timer;
    digit_n      = digit;
    double_tap_n = 1'b0;
    commit       = 1'b0;
    clear        = 1'b0;

    case (state)
      IDLE: begin
        if (inc_pulse) begin
          state_n = ARMED;
          timer_n = TIMER_LOAD;
        end
      end
      ARMED: begin
        // A second tap beats window expiry in the same cycle.
        if (inc_pulse) begin
          clear        = 1'b1;
          double_tap_n = 1'b1;
          timer_n      = '0;
          state_n      = IDLE;
        end else if (timer == '0) begin
          commit  = 1'b1;
          state_n = IDLE;
        end else begin
          timer_n = timer - TIMER_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase

    // Clear wins over decrement; a commit and a decrement cancel.
    if (clear) begin
      digit_n = '0;
    end else if (commit && !dec_pulse) begin
      digit_n = (digit == DIGIT_MAX) ? '0 : digit + DIGIT_W'(1);
    end else if (dec_pulse && !commit) begin
      digit_n = (digit == '0) ? DIGIT_MAX : digit - DIGIT_W'(1);
    end
  end

  seg7_decoder u_seg7 (
    .digit (digit),
    .seg   (seg)
  );

`ifdef TAP_DP_BLINK_EN
  // Follows the timer MSB while the window is open.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp <= 1'b0;
    end else begin
      dp <= (state_n == ARMED) & timer_n[TIMER_W-1];
    end
  end
`else
  assign dp = 1'b0;
`endif

endmodule

// File: tb/tb_tap_digit_ctrl.sv
// Self-checking bench for tap_digit_ctrl with an 8-cycle double-tap window.
module tb_tap_digit_ctrl;

  localparam int unsigned DTAP = 8;

  typedef struct {
    logic       rst;
    logic       inc;
    logic       dec;
    logic [3:0] d;
    logic       a;
    logic       dt;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       inc_pulse;
  logic       dec_pulse;
  logic [3:0] digit;
  logic [6:0] seg;
  logic       armed;
  logic       double_tap;
  logic       dp;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec;
  int   n_bad;
  int   cur;

  tap_digit_ctrl #(
    .MAX_DIGIT   (9),
    .DTAP_CYCLES (DTAP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .inc_pulse  (inc_pulse),
    .dec_pulse  (dec_pulse),
    .digit      (digit),
    .seg        (seg),
    .armed      (armed),
    .double_tap (double_tap),
    .dp         (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'h3F;
      4'd1: seg_of = 7'h06;
      4'd2: seg_of = 7'h5B;
      4'd3: seg_of = 7'h4F;
      4'd4: seg_of = 7'h66;
      4'd5: seg_of = 7'h6D;
      4'd6: seg_of = 7'h7D;
      4'd7: seg_of = 7'h07;
      4'd8: seg_of = 7'h7F;
      4'd9: seg_of = 7'h6F;
      default: seg_of = 7'h00;
    endcase
  endfunction

  task automatic add(input logic rst, input logic inc, input logic dec,
                     input int d, input logic a, input logic dt);
    vec_t v;
    v.rst = rst; v.inc = inc; v.dec = dec;
    v.d = 4'(d); v.a = a; v.dt = dt;
    vecs.push_back(v);
  endtask

  // Single tap left to expire: 1 arming cycle, DTAP-1 waiting, 1 commit.
  task automatic add_tap();
    add(1'b0, 1'b1, 1'b0, cur, 1'b1, 1'b0);
    repeat (DTAP - 1) add(1'b0, 1'b0, 1'b0, cur, 1'b1, 1'b0);
    cur = (cur == 9) ? 0 : cur + 1;
    add(1'b0, 1'b0, 1'b0, cur, 1'b0, 1'b0);
  endtask

  // Drive at the falling edge, queue the expectation, check after the rise.
  task automatic apply(input vec_t v);
    vec_t e;
    logic dp_ok;
    @(negedge clk);
    reset     = v.rst;
    inc_pulse = v.inc;
    dec_pulse = v.dec;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    n_vec++;
`ifdef TAP_DP_BLINK_EN
    dp_ok = e.a || (dp == 1'b0);
`else
    dp_ok = (dp == 1'b0);
`endif
    if (digit !== e.d || seg !== seg_of(e.d) || armed !== e.a ||
        double_tap !== e.dt || !dp_ok) begin
      n_bad++;
      $display("FAIL vec %0d: got digit=%0d seg=%h armed=%b dtap=%b dp=%b, want digit=%0d seg=%h armed=%b dtap=%b",
               n_vec, digit, seg, armed, double_tap, dp, e.d, seg_of(e.d), e.a, e.dt);
    end
  endtask

  task automatic hs(input logic rst, input logic inc, input logic dec,
                    input int d, input logic a, input logic dt);
    vec_t v;
    v.rst = rst; v.inc = inc; v.dec = dec;
    v.d = 4'(d); v.a = a; v.dt = dt;
    apply(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    cur   = 0;
    reset = 1'b1;
    inc_pulse = 1'b0;
    dec_pulse = 1'b0;

    // Reset, then a long idle stretch.
    add(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    repeat (20) add(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // Single tap 0 -> 1, then load up to 5.
    repeat (5) add_tap();
    // Double tap with second pulse on the last window edge.
    add(1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
    repeat (DTAP - 1) add(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    add(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    add(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    cur = 0;
    // Back to 5, then second pulse one edge too late: commit, new window.
    repeat (5) add_tap();
    add(1'b0, 1'b1, 1'b0, 5, 1'b1, 1'b0);
    repeat (DTAP - 1) add(1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 6, 1'b1, 1'b0);
    repeat (DTAP - 1) add(1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 7, 1'b0, 1'b0);
    cur = 7;
    // Wrap 9 -> 0 on a tap, then 0 -> 9 on a decrement.
    repeat (3) add_tap();
    add(1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 8, 1'b0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 8, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Decrement down to 3, then decrement on the commit edge cancels.
    for (int k = 7; k >= 3; k--) hs(1'b0, 1'b0, 1'b1, k, 1'b0, 1'b0);
    hs(1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    repeat (DTAP - 1) hs(1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    hs(1'b0, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    hs(1'b0, 1'b0, 1'b0, 3, 1'b0, 1'b0);

    // Decrement together with the second tap: clear wins.
    hs(1'b0, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    hs(1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0);
    hs(1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1);
    hs(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Decrement inside a window is immediate and leaves the timer alone.
    hs(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    hs(1'b0, 1'b0, 1'b1, 9, 1'b1, 1'b0);
    repeat (DTAP - 2) hs(1'b0, 1'b0, 1'b0, 9, 1'b1, 1'b0);
    hs(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // Held inc: arm, double tap, re-arm, then expire.
    hs(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    hs(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1);
    hs(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    repeat (DTAP - 1) hs(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    hs(1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // Reset at edge 4 of an open window discards the pending tap.
    hs(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0);
    repeat (3) hs(1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    hs(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    hs(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    repeat (10) hs(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
